// File: rtl/counters_checker.sv
// Streaming checker: locks onto a sequence advancing by STEP modulo 2^SIZE,
// then flags and counts every sample that breaks the sequence.
module counters_checker #(
    parameter int unsigned SIZE   = 10,
    parameter int unsigned STEP   = 2,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [SIZE-1:0]   in,
    input  logic              in_valid,
    output logic              locked,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_count,
    output logic [SIZE-1:0]   expected
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;

    localparam logic [SIZE-1:0]  STEP_V  = SIZE'(STEP);
    localparam logic [7:0]       LOCK_V  = 8'(LOCK_N);
    localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

    state_t            state_q;
    logic              seeded_q;
    logic [7:0]        run_q;
    logic              locked_q;
    logic              mismatch_q;
    logic [ERR_W-1:0]  err_q;
    logic [SIZE-1:0]   exp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            seeded_q   <= 1'b0;
            run_q      <= '0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
            err_q      <= '0;
            exp_q      <= '0;
        end else begin
            mismatch_q <= 1'b0;
            if (!en) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
                seeded_q <= 1'b0;
                run_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: state_q <= ACQ;
                    ACQ: if (in_valid) begin
                        if (!seeded_q) begin
                            exp_q    <= in + STEP_V;
                            seeded_q <= 1'b1;
                        end else if (in == exp_q) begin
                            exp_q <= exp_q + STEP_V;
                            if (run_q + 8'd1 == LOCK_V) begin
                                state_q  <= TRACK;
                                locked_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_q + 8'd1;
                            end
                        end else begin
                            // Re-seed silently: errors only count once tracking.
                            exp_q <= in + STEP_V;
                            run_q <= '0;
                        end
                    end
                    TRACK: if (in_valid) begin
                        if (in == exp_q) begin
                            exp_q <= exp_q + STEP_V;
                        end else begin
                            mismatch_q <= 1'b1;
                            if (err_q != '1)
                                err_q <= err_q + ERR_ONE;
                            exp_q    <= in + STEP_V;
                            state_q  <= ACQ;
                            seeded_q <= 1'b1;
                            run_q    <= '0;
                            locked_q <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            // Placed last so a clear wins over a same-edge increment.
            if (clr)
                err_q <= '0;
        end
    end

    assign locked    = locked_q;
    assign mismatch  = mismatch_q;
    assign err_count = err_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_counters_checker.sv
// Scoreboard bench for counters_checker: directed rows push expected outputs,
// a negedge monitor pops and compares them against two DUT instances.
module tb_counters_checker;

    logic       clk = 1'b0;
    logic       rst, en, clr, in_valid;
    logic [9:0] din;

    logic       locked_a, mismatch_a;
    logic [7:0] err_a;
    logic [9:0] exp_a;
    logic       locked_b, mismatch_b;
    logic [1:0] err_b;
    logic [9:0] exp_b;

    always #5 clk = ~clk;

    counters_checker #(.SIZE(10), .STEP(2), .LOCK_N(4), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(din), .in_valid(in_valid),
        .locked(locked_a), .mismatch(mismatch_a), .err_count(err_a), .expected(exp_a)
    );

    counters_checker #(.SIZE(10), .STEP(2), .LOCK_N(4), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(din), .in_valid(in_valid),
        .locked(locked_b), .mismatch(mismatch_b), .err_count(err_b), .expected(exp_b)
    );

    typedef struct {
        int         row;
        logic       lk;
        logic       mm;
        logic [7:0] err;
        logic [1:0] err2;
        logic [9:0] ex;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   row_n = 0;

    task automatic chk(input string name, input int row, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s row=%0d actual=%0d required=%0d", name, row, act, req);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic v,
                        input int d, input logic lk, input logic mm,
                        input int er, input int ex);
        exp_t t;
        rst = r; en = e; clr = c; in_valid = v; din = 10'(d);
        @(posedge clk);
        #1;
        row_n++;
        t.row  = row_n;
        t.lk   = lk;
        t.mm   = mm;
        t.err  = 8'(er);
        t.err2 = (er > 3) ? 2'd3 : 2'(er);
        t.ex   = 10'(ex);
        exp_q.push_back(t);
    endtask

    initial begin : monitor
        exp_t t;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                t = exp_q.pop_front();
                chk("locked",    t.row, int'(locked_a),   int'(t.lk));
                chk("mismatch",  t.row, int'(mismatch_a), int'(t.mm));
                chk("err_count", t.row, int'(err_a),      int'(t.err));
                chk("expected",  t.row, int'(exp_a),      int'(t.ex));
                chk("err_sat2",  t.row, int'(err_b),      int'(t.err2));
                chk("mm_w2",     t.row, int'(mismatch_b), int'(t.mm));
            end
        end
    end

    initial begin : driver
        int budget;
        rst = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0;
        //    rst en clr v  in    lk mm err exp
        step(1, 0, 0, 0, 0,     0, 0, 0, 0);
        step(0, 1, 0, 0, 0,     0, 0, 0, 0);
        // lock acquisition
        step(0, 1, 0, 1, 0,     0, 0, 0, 2);
        step(0, 1, 0, 1, 2,     0, 0, 0, 4);
        step(0, 1, 0, 1, 4,     0, 0, 0, 6);
        step(0, 1, 0, 1, 6,     0, 0, 0, 8);
        step(0, 1, 0, 1, 8,     1, 0, 0, 10);
        // gaps in TRACK
        step(0, 1, 0, 0, 123,   1, 0, 0, 10);
        step(0, 1, 0, 0, 77,    1, 0, 0, 10);
        step(0, 1, 0, 1, 10,    1, 0, 0, 12);
        step(0, 1, 0, 1, 12,    1, 0, 0, 14);
        // error and relock
        step(0, 1, 0, 1, 20,    0, 1, 1, 22);
        step(0, 1, 0, 1, 22,    0, 0, 1, 24);
        step(0, 1, 0, 1, 24,    0, 0, 1, 26);
        step(0, 1, 0, 1, 26,    0, 0, 1, 28);
        step(0, 1, 0, 1, 28,    1, 0, 1, 30);
        // disable while tracking, then reacquire near the wrap point
        step(0, 0, 0, 1, 30,    0, 0, 1, 30);
        step(0, 1, 0, 0, 0,     0, 0, 1, 30);
        step(0, 1, 0, 1, 1008,  0, 0, 1, 1010);
        step(0, 1, 0, 1, 1010,  0, 0, 1, 1012);
        step(0, 1, 0, 1, 1012,  0, 0, 1, 1014);
        step(0, 1, 0, 1, 1014,  0, 0, 1, 1016);
        step(0, 1, 0, 1, 1016,  1, 0, 1, 1018);
        step(0, 1, 0, 1, 1018,  1, 0, 1, 1020);
        step(0, 1, 0, 1, 1020,  1, 0, 1, 1022);
        step(0, 1, 0, 1, 1022,  1, 0, 1, 0);
        step(0, 1, 0, 1, 0,     1, 0, 1, 2);
        step(0, 1, 0, 1, 2,     1, 0, 1, 4);
        // upstream counter reset: one error, then relock
        step(0, 1, 0, 1, 0,     0, 1, 2, 2);
        step(0, 1, 0, 1, 2,     0, 0, 2, 4);
        step(0, 1, 0, 1, 4,     0, 0, 2, 6);
        step(0, 1, 0, 1, 6,     0, 0, 2, 8);
        step(0, 1, 0, 1, 8,     1, 0, 2, 10);
        // error 3, with a silent re-seed during ACQ
        step(0, 1, 0, 1, 100,   0, 1, 3, 102);
        step(0, 1, 0, 1, 50,    0, 0, 3, 52);
        step(0, 1, 0, 1, 52,    0, 0, 3, 54);
        step(0, 1, 0, 1, 54,    0, 0, 3, 56);
        step(0, 1, 0, 1, 56,    0, 0, 3, 58);
        step(0, 1, 0, 1, 58,    1, 0, 3, 60);
        // errors 4 and 5 (2-bit counter stays at 3)
        step(0, 1, 0, 1, 200,   0, 1, 4, 202);
        step(0, 1, 0, 1, 202,   0, 0, 4, 204);
        step(0, 1, 0, 1, 204,   0, 0, 4, 206);
        step(0, 1, 0, 1, 206,   0, 0, 4, 208);
        step(0, 1, 0, 1, 208,   1, 0, 4, 210);
        step(0, 1, 0, 1, 300,   0, 1, 5, 302);
        step(0, 1, 0, 1, 302,   0, 0, 5, 304);
        step(0, 1, 0, 1, 304,   0, 0, 5, 306);
        step(0, 1, 0, 1, 306,   0, 0, 5, 308);
        step(0, 1, 0, 1, 308,   1, 0, 5, 310);
        // clr on the same edge as a TRACK mismatch
        step(0, 1, 1, 1, 400,   0, 1, 0, 402);
        step(0, 1, 0, 0, 400,   0, 0, 0, 402);
        // gap inside ACQ
        step(0, 1, 0, 1, 402,   0, 0, 0, 404);
        step(0, 1, 0, 0, 999,   0, 0, 0, 404);
        step(0, 1, 0, 1, 404,   0, 0, 0, 406);
        step(0, 1, 0, 1, 406,   0, 0, 0, 408);
        step(0, 1, 0, 1, 408,   1, 0, 0, 410);
        // reset while tracking, then reacquire from scratch
        step(1, 1, 0, 1, 410,   0, 0, 0, 0);
        step(0, 1, 0, 1, 500,   0, 0, 0, 0);
        step(0, 1, 0, 1, 500,   0, 0, 0, 502);
        step(0, 1, 0, 1, 502,   0, 0, 0, 504);
        step(0, 1, 0, 1, 504,   0, 0, 0, 506);
        step(0, 1, 0, 1, 506,   0, 0, 0, 508);
        step(0, 1, 0, 1, 508,   1, 0, 0, 510);
        in_valid = 1'b0;
        budget = 0;
        while (exp_q.size() != 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counters_checker.md
# counters_checker

Streaming checker for the output of a counter bank: consumes the `SIZE`-bit sum produced by the dual-counter/adder datapath and verifies that each sample advances by a fixed `STEP` modulo 2^SIZE. It acquires lock on the incoming sequence, tracks it, and flags and counts every deviation. It sits downstream of the counter datapath, as its receiving end, in simulation benches and formal harnesses.

## Interface
- `SIZE`, 10, data width; must match the producing datapath.
- `STEP`, 2, expected increment per valid sample, taken modulo 2^SIZE.
- `LOCK_N`, 4, consecutive matching samples required to declare lock; range 1..255.
- `ERR_W`, 8, error counter width.

Ports:
- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  checker enable.
- `clr`  in  1  clears `err_count`.
- `in`  in  SIZE  sample from the counter datapath.
- `in_valid`  in  1  `in` is sampled on this edge.
- `locked`  out  1  sequence is being tracked.
- `mismatch`  out  1  one-cycle pulse per detected error.
- `err_count`  out  ERR_W  saturating error count.
- `expected`  out  SIZE  next predicted sample.

## Operation
- **State machine:** IDLE, ACQ, TRACK. There is also an internal `seeded` flag and a `run` counter (8 bits).
- **Reset** (`rst`=1 at an edge): state goes to IDLE. `seeded`=0, `run`=0. All outputs become 0: `locked`, `mismatch`, `err_count`, `expected`. Reset overrides every other input.
- **`en`=0 at an edge, any state:** go to IDLE next cycle. `locked`=0, `seeded`=0, `run`=0. `err_count` and `expected` are retained.
- **IDLE:**
  - `en`=1 moves to ACQ.
  - Samples arriving in the same edge are ignored.
- **ACQ**, on each valid sample:
  - If `seeded`=0: `expected` <= `in`+`STEP`, `seeded` <= 1.
  - Else, if `in`==`expected`: `expected` <= `expected`+`STEP` and `run` <= `run`+1. When `run`+1==`LOCK_N`, go to TRACK, set `locked` <= 1 and `run` <= 0.
  - Else (mismatch): re-seed with `expected` <= `in`+`STEP`, `run` <= 0. No error is counted and `mismatch` is not pulsed.
- **TRACK**, on each valid sample:
  - Match: `expected` <= `expected`+`STEP`.
  - Mismatch:
    - `mismatch` <= 1 for one cycle.
    - `err_count` increments, saturating at all-ones.
    - `expected` <= `in`+`STEP`.
    - Go to ACQ with `seeded`=1, `run`=0, `locked` <= 0.
- **`in_valid`=0:** state, `expected`, `run` and `seeded` all hold. `mismatch` is 0.
- **Arithmetic:** all additions are SIZE-bit, dropping the carry. Wrap-around from 2^SIZE−STEP to 0 is a match.
- **`clr`:** sets `err_count` <= 0 and has priority over a simultaneous increment. The `mismatch` pulse in that same cycle is still asserted.
- **Upstream counter reset mid-stream** (sample drops to 0): treated as an ordinary mismatch. It counts exactly one error, then the checker relocks.

## Timing
- All outputs are registered. Each reflects the sample taken at edge N from edge N onward, i.e. it is visible in cycle N+1.
- `mismatch` is exactly one cycle wide per offending sample. Back-to-back errors cannot occur, because the first error leaves TRACK.
- Lock latency, with samples every cycle from ACQ: 1 seed + `LOCK_N` matches. `locked` rises after the (`LOCK_N`+1)-th valid sample's edge.
- The first sample can be taken on the edge after the IDLE→ACQ edge.

## Test plan
- **Lock acquisition:** `rst`, then `en`=1. Feed 0,2,4,6,8 with `in_valid`=1 on consecutive cycles → `locked`=1 after the edge sampling 8, `expected`=10, `err_count`=0, `mismatch` never 1.
- **Wrap, `SIZE`=10:** once locked, feed 1018,1020,1022,0,2 → no mismatch, `locked` stays 1, `expected`=4.
- **Error and relock:** locked at `expected`=14, feed 20 → `mismatch`=1 for exactly one cycle, `err_count`=1, `locked`=0, `expected`=22. Then 22,24,26,28 → `locked`=1 again, `err_count` still 1.
- **Gaps and saturation:**
  - Insert `in_valid`=0 cycles between samples → no state or output change during gaps.
  - With `ERR_W`=2, produce 5 errors, relocking in between → `err_count`=3, stays 3.
- **`clr` priority:** `clr`=1 on the same edge as a TRACK mismatch with `err_count`=5 → `err_count`=0, `mismatch`=1.
- **Reset and disable mid-operation:**
  - `rst`=1 for one cycle while in TRACK → next cycle all outputs 0 and state IDLE. With `en`=1 held, the checker reacquires from scratch.
  - `en`=0 while in TRACK → `locked`=0, `err_count` retained.
